// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel aligned PWM block.
package pwm_pkg;

   typedef enum logic {ALIGN_EDGE, ALIGN_CENTER} pwm_align_e;

   typedef enum logic [1:0] {LOW_BOTH, HI_P, HI_N} dt_state_e;

   function automatic int duty_full(input int r);
      return 1 << r;
   endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary output pair with dead-time insertion for one PWM channel.
// Used by pwm_multi_aligned only when PWM_DEADTIME_EN is defined.
module pwm_deadtime
   import pwm_pkg::*;
#(
   parameter int DEAD_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic raw,
   output logic p,
   output logic n
);

   localparam int CW = $clog2(DEAD_CYC + 1);

   dt_state_e       st;
   logic [CW-1:0]   cnt;
   logic            tgt;

   // A target that flips before the count expires restarts the gap,
   // which is what swallows pulses shorter than the dead time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st  <= LOW_BOTH;
         cnt <= '0;
         tgt <= 1'b0;
         p   <= 1'b0;
         n   <= 1'b0;
      end else if (!en) begin
         st  <= LOW_BOTH;
         cnt <= '0;
         tgt <= 1'b0;
         p   <= 1'b0;
         n   <= 1'b0;
      end else begin
         unique case (st)
            LOW_BOTH: begin
               if (raw != tgt) begin
                  tgt <= raw;
                  cnt <= '0;
               end else if (cnt == CW'(DEAD_CYC - 1)) begin
                  st <= raw ? HI_P : HI_N;
                  p  <= raw;
                  n  <= !raw;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HI_P: begin
               if (!raw) begin
                  st  <= LOW_BOTH;
                  p   <= 1'b0;
                  tgt <= 1'b0;
                  cnt <= '0;
               end
            end
            HI_N: begin
               if (raw) begin
                  st  <= LOW_BOTH;
                  n   <= 1'b0;
                  tgt <= 1'b1;
                  cnt <= '0;
               end
            end
            default: st <= LOW_BOTH;
         endcase
      end
   end

endmodule

// File: rtl/pwm_multi_aligned.sv
// N-channel PWM, shared prescaler/counter, double-buffered duty, edge/center.
// Define PWM_DEADTIME_EN for complementary outputs with dead-time.
module pwm_multi_aligned
   import pwm_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int R        = 8,
   parameter int DEAD_CYC = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [31:0]             dvsr,
   input  logic                    align,
   input  logic                    duty_wr,
   input  logic [$clog2(N_CH)-1:0] duty_ch,
   input  logic [R:0]              duty_data,
   output logic [N_CH-1:0]         pwm_out,
   output logic                    period_start
`ifdef PWM_DEADTIME_EN
   ,
   output logic [N_CH-1:0]         pwm_out_n
`endif
);

   localparam int         CH_W    = $clog2(N_CH);
   localparam logic [R:0] FULL    = (R+1)'(duty_full(R));
   localparam logic [R-1:0] CNT_MAX = '1;

   logic [31:0]     q;
   logic [R-1:0]    cnt;
   logic            down;
   logic            en_q;
   logic            bnd_d;
   pwm_align_e      align_q;
   logic [R:0]      shadow [N_CH];
   logic [R:0]      act [N_CH];
   logic [R:0]      wr_val;
   logic [N_CH-1:0] pwm_raw;
   logic [N_CH-1:0] pwm_next;
   logic            tick;
   logic            wrap;
   logic            start;
   logic            load;

   assign tick   = (q == '0);
   assign start  = en && !en_q;
   assign load   = start || (en && en_q && wrap);
   assign wr_val = (duty_data > FULL) ? FULL : duty_data;

   always_comb begin
      wrap = 1'b0;
      if (tick) begin
         if (align_q == ALIGN_EDGE)
            wrap = (cnt == CNT_MAX);
         else
            wrap = down && (cnt == R'(1));
      end
   end

   always_comb begin
      pwm_next = '0;
      for (int i = 0; i < N_CH; i++)
         pwm_next[i] = ({1'b0, cnt} < act[i]);
   end

   // bnd_d delays the boundary one clk so period_start lines up
   // with the first registered compare of the new period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q            <= '0;
         cnt          <= '0;
         down         <= 1'b0;
         en_q         <= 1'b0;
         bnd_d        <= 1'b0;
         align_q      <= ALIGN_EDGE;
         period_start <= 1'b0;
         pwm_raw      <= '0;
      end else begin
         en_q <= en;
         if (!en) begin
            q            <= '0;
            cnt          <= '0;
            down         <= 1'b0;
            bnd_d        <= 1'b0;
            period_start <= 1'b0;
            pwm_raw      <= '0;
         end else begin
            q            <= (q == dvsr) ? '0 : q + 1;
            bnd_d        <= load;
            period_start <= bnd_d;
            pwm_raw      <= en_q ? pwm_next : '0;
            if (load) begin
               cnt     <= '0;
               down    <= 1'b0;
               align_q <= pwm_align_e'(align);
            end else if (tick) begin
               if (align_q == ALIGN_EDGE) begin
                  cnt <= cnt + 1'b1;
               end else if (!down) begin
                  if (cnt == CNT_MAX) begin
                     down <= 1'b1;
                     cnt  <= cnt - 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            shadow[i] <= '0;
            act[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (duty_wr && duty_ch == CH_W'(i))
               shadow[i] <= wr_val;
            if (load)
               act[i] <= shadow[i];
         end
      end
   end

`ifdef PWM_DEADTIME_EN
   for (genvar g = 0; g < N_CH; g++) begin : g_dt
      pwm_deadtime #(.DEAD_CYC(DEAD_CYC)) u_dt (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .raw   (pwm_raw[g]),
         .p     (pwm_out[g]),
         .n     (pwm_out_n[g])
      );
   end
`else
   assign pwm_out = pwm_raw;
`endif

endmodule
